// File: rtl/tl_rx_np_tag_tracker.sv
// Non-posted tag tracker: lowest-free tag allocation, completion matching.
// Define TL_RX_CPL_TIMEOUT_EN to retire tags whose completion never arrives.
module tl_rx_np_tag_tracker #(
  parameter int REQUESTER_ID_WIDTH  = 16,
  parameter int REQUESTER_TAG_WIDTH = 10,
  parameter int NUM_TAGS            = 32,
  parameter int TICK_CYCLES         = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_req,
  output logic                           alloc_gnt,
  output logic [REQUESTER_TAG_WIDTH-1:0] alloc_tag,
  input  logic                           cpl_valid,
  input  logic [REQUESTER_ID_WIDTH-1:0]  cpl_req_id,
  input  logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag,
  input  logic                           cpl_last,
  input  logic [REQUESTER_ID_WIDTH-1:0]  own_req_id,
  input  logic                           uc_en,
  output logic                           cpl_ok,
  output logic                           uc_error,
  output logic [$clog2(NUM_TAGS):0]      outstanding_cnt,
  output logic                           all_busy,
  output logic                           timeout_valid,
  output logic [REQUESTER_TAG_WIDTH-1:0] timeout_tag
);
  localparam int IW = $clog2(NUM_TAGS);
  localparam int TW = REQUESTER_TAG_WIDTH;
  localparam logic [TW:0] TAG_LIM = (TW+1)'(NUM_TAGS);

  logic [NUM_TAGS-1:0] busy_q;
  logic [NUM_TAGS-1:0] alloc_mask;
  logic [NUM_TAGS-1:0] rel_mask;
  logic [NUM_TAGS-1:0] exp_mask;
  logic [IW-1:0]       free_idx;
  logic [IW-1:0]       cpl_idx;
  logic                any_free;
  logic                cpl_hit;

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    outstanding_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      outstanding_cnt = outstanding_cnt + (IW+1)'(busy_q[i]);
  end

  assign alloc_gnt = alloc_req && any_free;
  assign alloc_tag = TW'(free_idx);
  assign all_busy  = !any_free;

  // Upper tag bits must be zero; the low bits alone index the bitmap.
  assign cpl_idx = cpl_tag[IW-1:0];
  assign cpl_hit = cpl_valid && (cpl_req_id == own_req_id)
                && ({1'b0, cpl_tag} < TAG_LIM) && busy_q[cpl_idx];

  assign alloc_mask = alloc_gnt ? (NUM_TAGS'(1) << free_idx) : '0;
  assign rel_mask   = (cpl_hit && cpl_last) ? (NUM_TAGS'(1) << cpl_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= '0;
      cpl_ok   <= 1'b0;
      uc_error <= 1'b0;
    end else begin
      busy_q   <= (busy_q & ~rel_mask & ~exp_mask) | alloc_mask;
      cpl_ok   <= cpl_hit;
      uc_error <= cpl_valid && !cpl_hit && uc_en;
    end
  end

`ifdef TL_RX_CPL_TIMEOUT_EN
  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0]       tick_q;
  logic                tick;
  logic [1:0]          age_q [NUM_TAGS];
  logic [NUM_TAGS-1:0] pend_q;
  logic [NUM_TAGS-1:0] pend_pick;
  logic [IW-1:0]       pend_idx;
  logic                any_pend;

  assign tick = (tick_q == CW'(TICK_CYCLES - 1));

  // A release in the same cycle takes precedence over expiry.
  always_comb begin
    exp_mask = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      exp_mask[i] = tick && busy_q[i] && (age_q[i] == 2'd3) && !rel_mask[i];
  end

  always_comb begin
    pend_idx = '0;
    any_pend = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pend_idx = IW'(i);
        any_pend = 1'b1;
      end
    end
  end

  assign pend_pick = any_pend ? (NUM_TAGS'(1) << pend_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q        <= '0;
      pend_q        <= '0;
      timeout_valid <= 1'b0;
      timeout_tag   <= '0;
      for (int i = 0; i < NUM_TAGS; i++)
        age_q[i] <= '0;
    end else begin
      tick_q        <= tick ? '0 : tick_q + 1'b1;
      pend_q        <= (pend_q & ~pend_pick) | exp_mask;
      timeout_valid <= any_pend;
      timeout_tag   <= TW'(pend_idx);
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_mask[i])
          age_q[i] <= '0;
        else if (tick && busy_q[i] && age_q[i] != 2'd3)
          age_q[i] <= age_q[i] + 2'd1;
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick   = (TICK_CYCLES > 1);
  assign exp_mask      = '0;
  assign timeout_valid = 1'b0;
  assign timeout_tag   = '0;
`endif

endmodule

// File: tb/tb_tl_rx_np_tag_tracker.sv
// Bench for tl_rx_np_tag_tracker: vector table plus scoreboard queue.
// Timeout sequence runs when TL_RX_CPL_TIMEOUT_EN is defined.
module tb_tl_rx_np_tag_tracker;
  localparam int IDW  = 16;
  localparam int TAGW = 10;
  localparam int NT   = 32;
  localparam int CW   = $clog2(NT) + 1;
  localparam int TICK = 64;
  localparam int OWN  = 'h0100;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            alloc_req = 1'b0;
  logic            alloc_gnt;
  logic [TAGW-1:0] alloc_tag;
  logic            cpl_valid = 1'b0;
  logic [IDW-1:0]  cpl_req_id = '0;
  logic [TAGW-1:0] cpl_tag = '0;
  logic            cpl_last = 1'b0;
  logic [IDW-1:0]  own_req_id = IDW'(OWN);
  logic            uc_en = 1'b0;
  logic            cpl_ok;
  logic            uc_error;
  logic [CW-1:0]   outstanding_cnt;
  logic            all_busy;
  logic            timeout_valid;
  logic [TAGW-1:0] timeout_tag;

  always #5 clk = ~clk;

  tl_rx_np_tag_tracker #(
    .REQUESTER_ID_WIDTH (IDW),
    .REQUESTER_TAG_WIDTH(TAGW),
    .NUM_TAGS           (NT),
    .TICK_CYCLES        (TICK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_gnt      (alloc_gnt),
    .alloc_tag      (alloc_tag),
    .cpl_valid      (cpl_valid),
    .cpl_req_id     (cpl_req_id),
    .cpl_tag        (cpl_tag),
    .cpl_last       (cpl_last),
    .own_req_id     (own_req_id),
    .uc_en          (uc_en),
    .cpl_ok         (cpl_ok),
    .uc_error       (uc_error),
    .outstanding_cnt(outstanding_cnt),
    .all_busy       (all_busy),
    .timeout_valid  (timeout_valid),
    .timeout_tag    (timeout_tag)
  );

  typedef struct {
    logic            alloc;
    logic            cv;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    logic            last;
    logic            ue;
    logic            gnt;
    logic [TAGW-1:0] atag;
    logic            ok;
    logic            uc;
    logic [CW-1:0]   cnt;
    logic            full;
  } vec_t;

  typedef struct {
    logic          ok;
    logic          uc;
    logic [CW-1:0] cnt;
    logic          full;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int a, int cv, int id, int tag, int last,
                              int ue, int gnt, int atag, int ok, int uc,
                              int cnt, int full);
    vec_t v;
    v.alloc = a[0];
    v.cv    = cv[0];
    v.id    = IDW'(id);
    v.tag   = TAGW'(tag);
    v.last  = last[0];
    v.ue    = ue[0];
    v.gnt   = gnt[0];
    v.atag  = TAGW'(atag);
    v.ok    = ok[0];
    v.uc    = uc[0];
    v.cnt   = CW'(cnt);
    v.full  = full[0];
    return v;
  endfunction

  // Entered just after a falling edge; leaves just after the next one.
  task automatic apply(vec_t v, string nm);
    exp_t e;
    alloc_req  = v.alloc;
    cpl_valid  = v.cv;
    cpl_req_id = v.id;
    cpl_tag    = v.tag;
    cpl_last   = v.last;
    uc_en      = v.ue;
    #1;
    chk({nm, ".gnt"}, 32'(alloc_gnt), 32'(v.gnt));
    chk({nm, ".atag"}, 32'(alloc_tag), 32'(v.atag));
    e.ok   = v.ok;
    e.uc   = v.uc;
    e.cnt  = v.cnt;
    e.full = v.full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".ok"}, 32'(cpl_ok), 32'(e.ok));
    chk({nm, ".uc"}, 32'(uc_error), 32'(e.uc));
    chk({nm, ".cnt"}, 32'(outstanding_cnt), 32'(e.cnt));
    chk({nm, ".full"}, 32'(all_busy), 32'(e.full));
    @(negedge clk);
    alloc_req = 1'b0;
    cpl_valid = 1'b0;
    cpl_last  = 1'b0;
  endtask

  task automatic do_reset(string nm);
    rst       = 1'b0;
    alloc_req = 1'b0;
    cpl_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, ".ok"}, 32'(cpl_ok), 0);
    chk({nm, ".uc"}, 32'(uc_error), 0);
    chk({nm, ".cnt"}, 32'(outstanding_cnt), 0);
    chk({nm, ".full"}, 32'(all_busy), 0);
    chk({nm, ".tv"}, 32'(timeout_valid), 0);
    chk({nm, ".tt"}, 32'(timeout_tag), 0);
    chk({nm, ".atag"}, 32'(alloc_tag), 0);
    rst = 1'b1;
  endtask

`ifdef TL_RX_CPL_TIMEOUT_EN
  task automatic timeout_seq();
    int c;
    do_reset("rst_to");
    apply(mk(1, 0, OWN, 0, 0, 1, 1, 0, 0, 0, 1, 0), "to_a0");
    apply(mk(1, 0, OWN, 0, 0, 1, 1, 1, 0, 0, 2, 0), "to_a1");
    c = 0;
    @(posedge clk);
    #1;
    while (!timeout_valid && c < 8 * TICK) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("to.first_valid", 32'(timeout_valid), 1);
    chk("to.first_tag", 32'(timeout_tag), 0);
    chk("to.cnt", 32'(outstanding_cnt), 0);
    @(posedge clk);
    #1;
    chk("to.second_valid", 32'(timeout_valid), 1);
    chk("to.second_tag", 32'(timeout_tag), 1);
    @(posedge clk);
    #1;
    chk("to.drained", 32'(timeout_valid), 0);
    @(negedge clk);
    apply(mk(0, 1, OWN, 0, 1, 1, 0, 0, 0, 1, 0, 0), "to_late_cpl");
  endtask
`endif

  initial begin
    do_reset("rst0");

    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 1, 0, 0, 2, 0));
    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 2, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, OWN, 1, 1, 0, 0, 3, 1, 0, 2, 0));
    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 1, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, OWN, 5, 1, 1, 0, 3, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, OWN, 0, 0, 1, 0, 3, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 'h0200, 0, 1, 1, 0, 3, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, OWN, 0, 0, 1, 0, 3, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, OWN, 5, 1, 0, 0, 3, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 'h0200, 0, 1, 0, 0, 3, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, OWN, 0, 0, 1, 0, 3, 1, 0, 3, 0));
    vecs.push_back(mk(0, 1, OWN, 32, 1, 1, 0, 3, 0, 1, 3, 0));
    vecs.push_back(mk(1, 1, OWN, 2, 1, 1, 1, 3, 1, 0, 3, 0));
    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 2, 0, 0, 4, 0));
    vecs.push_back(mk(1, 1, OWN, 4, 1, 1, 1, 4, 0, 1, 5, 0));
    for (int i = 5; i < NT; i++)
      vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, i, 0, 0, i + 1,
                        (i == NT - 1) ? 1 : 0));
    vecs.push_back(mk(1, 1, OWN, 7, 1, 1, 0, 0, 1, 0, NT - 1, 0));
    vecs.push_back(mk(1, 0, OWN, 0, 0, 0, 1, 7, 0, 0, NT, 1));

    foreach (vecs[k])
      apply(vecs[k], $sformatf("v%0d", k));

    do_reset("rst_full");
    for (int i = 0; i < 10; i++)
      apply(mk(1, 0, OWN, 0, 0, 0, 1, i, 0, 0, i + 1, 0),
            $sformatf("r%0d", i));
    do_reset("rst_mid");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d.tv", i), 32'(timeout_valid), 0);
      @(negedge clk);
    end
    apply(mk(1, 0, OWN, 0, 0, 0, 1, 0, 0, 0, 1, 0), "post_rst");

`ifdef TL_RX_CPL_TIMEOUT_EN
    timeout_seq();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_rx_np_tag_tracker.md
Name: tl_rx_np_tag_tracker

Overview:
- Tracks outstanding non-posted (NP) requests by tag, shared between the TX request path (allocation) and the RX completion path (release).
- Allocates the lowest free tag to the TX side.
- Validates each received completion against the owning requester ID and the live tag set; flags unexpected completions.
- Optionally retires tags whose completion never arrives (completion timeout).
- Sits between the TX NP request generator and the RX write handler's error-check stage.

Parameters:
- REQUESTER_ID_WIDTH, 16, requester/completer ID width.
- REQUESTER_TAG_WIDTH, 10, tag field width on ports.
- NUM_TAGS, 32, tracked tags; power of two, 2 to 2^REQUESTER_TAG_WIDTH.
- TICK_CYCLES, 4096, clock cycles per timeout age tick (≥2).

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-low reset.
- alloc_req, input, 1, TX side requests a tag for a new NP TLP.
- alloc_gnt, output, 1, combinational grant; tag consumed in the cycle alloc_req && alloc_gnt.
- alloc_tag, output, REQUESTER_TAG_WIDTH, lowest free tag, zero-extended; 0 when none free.
- cpl_valid, input, 1, one completion header presented this cycle.
- cpl_req_id, input, REQUESTER_ID_WIDTH, requester ID field of the completion.
- cpl_tag, input, REQUESTER_TAG_WIDTH, tag field of the completion.
- cpl_last, input, 1, final completion for this request; releases the tag.
- own_req_id, input, REQUESTER_ID_WIDTH, this function's ID.
- uc_en, input, 1, unexpected-completion reporting enable.
- cpl_ok, output, 1, registered pulse: completion matched.
- uc_error, output, 1, registered pulse: unexpected completion.
- outstanding_cnt, output, $clog2(NUM_TAGS)+1, popcount of busy tags, from registered state.
- all_busy, output, 1, no free tag (alloc_gnt held 0).
- timeout_valid, output, 1, registered pulse, one timed-out tag reported.
- timeout_tag, output, REQUESTER_TAG_WIDTH, tag accompanying timeout_valid.

Behaviour:
- Reset (rst==0 at clk edge):
  - busy, age, pending-timeout bitmaps and tick counter cleared.
  - cpl_ok, uc_error, timeout_valid, timeout_tag all 0; outstanding_cnt 0; all_busy 0.
- Allocation:
  - alloc_gnt = alloc_req && any tag free. alloc_tag = priority-encoded lowest free index from the registered busy bitmap.
  - On grant, busy[tag] is set and age[tag] cleared at the next edge. Maximum one allocation per cycle.
- Completion check: on cpl_valid, the completion matches when cpl_req_id==own_req_id, cpl_tag<NUM_TAGS and busy[cpl_tag]==1.
  - Match: cpl_ok=1 the next cycle. If cpl_last, busy[cpl_tag] cleared at that same edge.
  - No match: uc_error=1 the next cycle if uc_en, else 0. Tracker state unchanged.
  - Latency is 1 cycle. cpl_ok and uc_error are never both 1 and last exactly 1 cycle per completion.
- Simultaneous events:
  - Allocation and release in the same cycle: both take effect. The freed tag is not visible to the allocator until the next cycle.
  - A completion for a tag being allocated in the same cycle is unexpected, because busy is still 0.
  - Release and timeout of the same tag in the same cycle: the release wins. No timeout is reported.
- outstanding_cnt and all_busy are derived combinationally from the registered busy bitmap, so they reflect state 1 cycle after the event.
- Reset mid-operation discards all outstanding tags silently. No timeout or error is reported for them.

Optional Feature:
- Macro: TL_RX_CPL_TIMEOUT_EN.
- When defined:
  - Tick counter counts 0..TICK_CYCLES-1 and asserts tick on wrap.
  - On tick, every busy tag's 2-bit age saturating-increments.
  - A busy tag whose age is 3 when tick fires is cleared from busy and set in the pending bitmap.
  - Each cycle, the lowest pending tag is reported: timeout_valid=1 and timeout_tag=index for 1 cycle, and its pending bit is cleared. Further pending tags follow on consecutive cycles.
  - A completion for a timed-out tag is unexpected.
  - Timeout fires 3 to 4 ticks after allocation.
- When not defined: no tick counter or age storage; timeout_valid and timeout_tag tied to 0.

Test Plan:
- Reset, then alloc_req held 3 cycles -> alloc_tag 0,1,2 with alloc_gnt=1 each cycle; outstanding_cnt reaches 3 one cycle after the third grant.
- Tag 1 busy; cpl_valid with cpl_req_id=own_req_id=16'h0100, cpl_tag=1, cpl_last=1 -> cpl_ok=1 next cycle; next alloc_tag=1; outstanding_cnt decrements by 1.
- uc_en=1; completion with cpl_tag=5 (free), then with cpl_req_id=16'h0200 and busy tag 0 -> uc_error pulses twice, 1 cycle each; with uc_en=0 the same stimulus gives uc_error=0.
- Allocate all 32 tags -> all_busy=1, alloc_gnt=0. Same cycle: alloc_req plus a releasing completion for tag 7 -> no grant that cycle; tag 7 granted the next cycle.
- TL_RX_CPL_TIMEOUT_EN, TICK_CYCLES=4: allocate tags 0 and 1 with no completions -> both retire on the same tick; timeout_tag=0 then 1 on consecutive cycles. A later completion for tag 0 gives uc_error=1.
- Assert rst=0 for 1 cycle with 10 tags busy -> outstanding_cnt=0, next alloc_tag=0, no timeout_valid afterwards.
